// File: rtl/frame_gen_pkg.sv
// frame_gen_pkg: shared constants, state encoding and length clamp for the test-frame generator
package frame_gen_pkg;
   localparam logic [15:0] ETHERTYPE_TEST = 16'h88B5;
   localparam int MIN_LEN = 60;
   localparam int MAX_LEN = 1514;
   localparam int BEAT_BYTES = 64;
   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
   function automatic logic [10:0] clamp_len(input logic [10:0] len);
      return len < 11'(MIN_LEN) ? 11'(MIN_LEN) : len > 11'(MAX_LEN) ? 11'(MAX_LEN) : len;
   endfunction
endpackage

// File: rtl/frame_beat_builder.sv
// frame_beat_builder: combinational data/keep/last for one beat of a test frame
module frame_beat_builder
   import frame_gen_pkg::*;
#(
   parameter int DATA_WIDTH = 512
) (
   input  logic [4:0]              beat,
   input  logic [10:0]             len,
   input  logic [47:0]             dst_mac,
   input  logic [47:0]             src_mac,
   input  logic [63:0]             seq,
   input  logic [63:0]             ts,
   output logic [DATA_WIDTH-1:0]   data,
   output logic [DATA_WIDTH/8-1:0] keep,
   output logic                    last
);
   logic [239:0] hdr;
   assign hdr = {dst_mac, src_mac, ETHERTYPE_TEST, seq, ts};
   assign last = {6'd0, beat} == (len - 11'd1) >> 6;
   for (genvar i = 0; i < DATA_WIDTH / 8; i++) begin : g_byte
      logic [10:0] idx;
      assign idx = {beat, 6'(i)};
      assign keep[i] = idx < len;
      // header bytes only exist in beat 0; everything else is the byte index
      if (i < 30) begin : g_hdr
         assign data[8*i +: 8] = !keep[i] ? '0 : beat == '0 ? hdr[239-8*i -: 8] : idx[7:0];
      end else begin : g_pay
         assign data[8*i +: 8] = keep[i] ? idx[7:0] : '0;
      end
   end
endmodule

// File: rtl/frame_generator.sv
// frame_generator: AXIS test-frame source with sequence numbers, TX timestamps and sent counters
module frame_generator
   import frame_gen_pkg::*;
#(
   parameter int DATA_WIDTH = 512,
   parameter int ID_WIDTH = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   output logic                    ready,
   input  logic                    start,
   input  logic                    stop,
   input  logic [10:0]             cfg_frame_len,
   input  logic [31:0]             cfg_frame_count,
   input  logic [15:0]             cfg_gap,
   input  logic [47:0]             cfg_dst_mac,
   input  logic [47:0]             cfg_src_mac,
   input  logic [ID_WIDTH-1:0]     cfg_id,
   output logic [127:0]            result,
   output logic [DATA_WIDTH-1:0]   axis_m_data,
   output logic [DATA_WIDTH/8-1:0] axis_m_keep,
   output logic                    axis_m_last,
   output logic [DATA_WIDTH/8-1:0] axis_m_user,
   output logic [ID_WIDTH-1:0]     axis_m_id,
   output logic                    axis_m_valid,
   input  logic                    axis_m_ready
);
   state_t state, state_nx;
   logic [10:0] len;
   logic [31:0] count;
   logic [15:0] gap, gap_cnt;
   logic [47:0] dst_mac, src_mac;
   logic [ID_WIDTH-1:0] id;
   logic [63:0] ts, ts_frame, frames, bytes_sent;
   logic [4:0] beat;
   logic ts_held, stop_pending, fire, eof, done;
   logic [DATA_WIDTH-1:0] beat_data;
   logic [DATA_WIDTH/8-1:0] beat_keep;
   logic beat_last;

   // frames doubles as the sequence number: both clear on start and step per frame
   frame_beat_builder #(.DATA_WIDTH(DATA_WIDTH)) u_builder (
      .beat    (beat),
      .len     (len),
      .dst_mac (dst_mac),
      .src_mac (src_mac),
      .seq     (frames),
      .ts      (ts_held ? ts_frame : ts),
      .data    (beat_data),
      .keep    (beat_keep),
      .last    (beat_last)
   );

   assign fire = state == SEND && axis_m_ready;
   assign eof = fire && beat_last;
   assign done = stop_pending || stop || (count != '0 && frames + 64'd1 == 64'(count));

   always_comb begin
      state_nx = state;
      ready = state == IDLE;
      axis_m_valid = state == SEND;
      axis_m_data = state == SEND ? beat_data : '0;
      axis_m_keep = state == SEND ? beat_keep : '0;
      axis_m_last = state == SEND && beat_last;
      axis_m_user = '0;
      axis_m_id = id;
      result = {frames, bytes_sent};
      if (state == IDLE && start) state_nx = SEND;
      else if (eof) state_nx = done ? IDLE : gap != '0 ? GAP : SEND;
      else if (state == GAP && (stop || gap_cnt == 16'd1)) state_nx = stop ? IDLE : SEND;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         ts <= '0;
         ts_frame <= '0;
         ts_held <= 1'b0;
         len <= 11'(MIN_LEN);
         count <= '0;
         gap <= '0;
         gap_cnt <= '0;
         dst_mac <= '0;
         src_mac <= '0;
         id <= '0;
         frames <= '0;
         bytes_sent <= '0;
         beat <= '0;
         stop_pending <= 1'b0;
      end else begin
         state <= state_nx;
         ts <= ts + 64'd1;
         if (state == IDLE && start) begin
            len <= clamp_len(cfg_frame_len);
            count <= cfg_frame_count;
            gap <= cfg_gap;
            dst_mac <= cfg_dst_mac;
            src_mac <= cfg_src_mac;
            id <= cfg_id;
            frames <= '0;
            bytes_sent <= '0;
            stop_pending <= 1'b0;
         end
         if (state == SEND) begin
            if (beat == '0 && !ts_held) begin
               ts_frame <= ts;
               ts_held <= 1'b1;
            end
            if (stop) stop_pending <= 1'b1;
            if (fire) beat <= beat_last ? '0 : beat + 5'd1;
            if (eof) begin
               frames <= frames + 64'd1;
               bytes_sent <= bytes_sent + 64'(len);
               ts_held <= 1'b0;
               gap_cnt <= gap;
            end
         end
         if (state == GAP) gap_cnt <= gap_cnt - 16'd1;
      end
   end
endmodule

// File: tb/tb_frame_generator.sv
// tb_frame_generator: vector table plus randomized runs checked against a byte-level frame model
module tb_frame_generator;
   localparam int DW = 512;
   localparam int KW = DW / 8;
   localparam int IW = 3;

   logic clk = 1'b0, rst = 1'b1;
   logic ready, start = 1'b0, stop = 1'b0;
   logic [10:0] cfg_frame_len = '0;
   logic [31:0] cfg_frame_count = '0;
   logic [15:0] cfg_gap = '0;
   logic [47:0] cfg_dst_mac = '0, cfg_src_mac = '0;
   logic [IW-1:0] cfg_id = '0;
   logic [127:0] result;
   logic [DW-1:0] axis_m_data;
   logic [KW-1:0] axis_m_keep, axis_m_user;
   logic axis_m_last, axis_m_valid, axis_m_ready = 1'b0;
   logic [IW-1:0] axis_m_id;

   frame_generator #(.DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
      .clk(clk), .rst(rst), .ready(ready), .start(start), .stop(stop),
      .cfg_frame_len(cfg_frame_len), .cfg_frame_count(cfg_frame_count), .cfg_gap(cfg_gap),
      .cfg_dst_mac(cfg_dst_mac), .cfg_src_mac(cfg_src_mac), .cfg_id(cfg_id),
      .result(result), .axis_m_data(axis_m_data), .axis_m_keep(axis_m_keep),
      .axis_m_last(axis_m_last), .axis_m_user(axis_m_user), .axis_m_id(axis_m_id),
      .axis_m_valid(axis_m_valid), .axis_m_ready(axis_m_ready)
   );

   always #5 clk = ~clk;

   // cycles elapsed since reset release; equals the expected timestamp value at each negedge
   logic [63:0] cyc;
   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= '0;
      else cyc <= cyc + 64'd1;
   end

   typedef struct {
      int len; int count; int gap; bit rnd; int exp_beats;
      logic [63:0] exp_frames; logic [63:0] exp_bytes; logic [63:0] exp_keep;
   } vec_t;
   vec_t v[6];

   int n_checks = 0, n_fail = 0, n_beats = 0;
   bit rnd_ready = 1'b0;
   bit m_active = 1'b0, m_stop = 1'b0, m_ts_known = 1'b0, m_just_ended = 1'b0, last_valid = 1'b0;
   int m_len = 60, m_gap = 0, m_beat = 0;
   logic [31:0] m_count = '0;
   logic [47:0] m_dst = '0, m_src = '0;
   logic [IW-1:0] m_id = '0;
   logic [63:0] m_frames = '0, m_bytes = '0, m_ts = '0, m_next_cyc = '0, last_keep = '0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int clamp(input int len);
      return len < 60 ? 60 : len > 1514 ? 1514 : len;
   endfunction

   function automatic logic [DW-1:0] exp_data(input int b);
      logic [DW-1:0] d = '0;
      for (int i = 0; i < KW; i++) begin
         int idx;
         logic [7:0] x;
         idx = b * 64 + i;
         if (idx >= m_len) x = 8'h00;
         else if (idx < 6) x = m_dst[8*(5-idx) +: 8];
         else if (idx < 12) x = m_src[8*(11-idx) +: 8];
         else if (idx == 12) x = 8'h88;
         else if (idx == 13) x = 8'hB5;
         else if (idx < 22) x = m_frames[8*(21-idx) +: 8];
         else if (idx < 30) x = m_ts[8*(29-idx) +: 8];
         else x = 8'(idx);
         d[8*i +: 8] = x;
      end
      return d;
   endfunction

   function automatic logic [KW-1:0] exp_keep(input int b);
      logic [KW-1:0] k = '0;
      for (int i = 0; i < KW; i++) k[i] = b * 64 + i < m_len;
      return k;
   endfunction

   task automatic monitor(input bit rdy);
      bit exp_valid, is_last;
      m_just_ended = 1'b0;
      exp_valid = m_active && (m_beat > 0 || cyc >= m_next_cyc);
      is_last = (m_beat + 1) * 64 >= m_len;
      chk("valid", axis_m_valid, exp_valid);
      chk("ready", ready, !m_active);
      chk("result", result, {m_frames, m_bytes});
      last_valid = axis_m_valid;
      if (exp_valid) begin
         if (m_beat == 0 && !m_ts_known) begin
            m_ts = cyc;
            m_ts_known = 1'b1;
         end
         chk("data", axis_m_data, exp_data(m_beat));
         chk("keep", axis_m_keep, exp_keep(m_beat));
         chk("last", axis_m_last, is_last);
         chk("id", axis_m_id, m_id);
         if (rdy) begin
            n_beats++;
            if (is_last) begin
               last_keep = axis_m_keep;
               m_frames++;
               m_bytes += 64'(m_len);
               m_beat = 0;
               m_ts_known = 1'b0;
               m_next_cyc = cyc + 64'(m_gap) + 64'd1;
               if (m_stop || (m_count != 0 && m_frames == 64'(m_count))) m_active = 1'b0;
               else m_just_ended = 1'b1;
            end else m_beat++;
         end
      end
   endtask

   task automatic tick();
      bit r;
      @(negedge clk);
      r = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      start = 1'b0;
      stop = 1'b0;
      monitor(r);
      axis_m_ready = r;
   endtask

   task automatic do_start(input int len, input int count, input int gap);
      cfg_frame_len = 11'(len);
      cfg_frame_count = 32'(count);
      cfg_gap = 16'(gap);
      cfg_dst_mac = {16'($urandom), 32'($urandom)};
      cfg_src_mac = {16'($urandom), 32'($urandom)};
      cfg_id = IW'($urandom);
      start = 1'b1;
      m_len = clamp(len);
      m_count = 32'(count);
      m_gap = gap;
      m_dst = cfg_dst_mac;
      m_src = cfg_src_mac;
      m_id = cfg_id;
      m_frames = '0;
      m_bytes = '0;
      m_beat = 0;
      m_ts_known = 1'b0;
      m_stop = 1'b0;
      m_active = 1'b1;
      m_next_cyc = cyc + 64'd1;
      n_beats = 0;
   endtask

   task automatic do_stop();
      stop = 1'b1;
      if (m_active) begin
         if (m_just_ended || !last_valid) m_active = 1'b0;
         else m_stop = 1'b1;
      end
   endtask

   task automatic run_idle(input int budget);
      for (int k = 0; k < budget && m_active; k++) tick();
      if (m_active) begin
         n_checks++;
         n_fail++;
         $display("FAIL timeout: generator still busy after %0d cycles, required idle", budget);
         m_active = 1'b0;
      end
      repeat (3) tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      v[0] = '{60, 1, 0, 1'b0, 1, 64'd1, 64'd60, 64'h0FFF_FFFF_FFFF_FFFF};
      v[1] = '{130, 3, 0, 1'b0, 9, 64'd3, 64'd390, 64'h3};
      v[2] = '{1514, 2, 0, 1'b1, 48, 64'd2, 64'd3028, 64'h3FF_FFFF_FFFF};
      v[3] = '{10, 1, 0, 1'b0, 1, 64'd1, 64'd60, 64'h0FFF_FFFF_FFFF_FFFF};
      v[4] = '{2000, 1, 3, 1'b1, 24, 64'd1, 64'd1514, 64'h3FF_FFFF_FFFF};
      v[5] = '{200, 4, 2, 1'b1, 16, 64'd4, 64'd800, 64'hFF};
      repeat (2) @(negedge clk);
      chk("rst_ready", ready, 1'b1);
      chk("rst_valid", axis_m_valid, 1'b0);
      chk("rst_last", axis_m_last, 1'b0);
      chk("rst_data", axis_m_data, '0);
      chk("rst_keep", axis_m_keep, '0);
      chk("rst_user", axis_m_user, '0);
      chk("rst_id", axis_m_id, '0);
      chk("rst_result", result, '0);
      rst = 1'b0;
      tick();

      foreach (v[i]) begin
         rnd_ready = v[i].rnd;
         do_start(v[i].len, v[i].count, v[i].gap);
         repeat (5) tick();
         if (m_active) begin
            cfg_frame_len = 11'd777;
            cfg_gap = 16'd9;
            cfg_dst_mac = '0;
            start = 1'b1;
         end
         run_idle(4000);
         chk("tbl_frames", result[127:64], v[i].exp_frames);
         chk("tbl_bytes", result[63:0], v[i].exp_bytes);
         chk("tbl_beats", n_beats, v[i].exp_beats);
         chk("tbl_last_keep", last_keep, v[i].exp_keep);
         chk("tbl_user", axis_m_user, '0);
      end

      for (int r = 0; r < 6; r++) begin
         int len, count, gap;
         len = $urandom_range(0, 2047);
         count = $urandom_range(1, 3);
         gap = $urandom_range(0, 4);
         rnd_ready = 1'b1;
         do_start(len, count, gap);
         run_idle(4000);
         chk("rand_frames", result[127:64], 64'(count));
         chk("rand_bytes", result[63:0], 64'(count * clamp(len)));
      end

      rnd_ready = 1'b0;
      do_start(64, 0, 5);
      repeat (30) tick();
      do_stop();
      run_idle(200);

      do_start(300, 0, 0);
      for (int k = 0; k < 500 && !(m_frames == 1 && m_beat == 2); k++) tick();
      do_stop();
      run_idle(200);
      chk("stop_mid_frame", result, {64'd2, 64'd600});

      do_start(60, 0, 20);
      for (int k = 0; k < 500 && m_frames != 1; k++) tick();
      repeat (3) tick();
      do_stop();
      run_idle(200);
      chk("stop_in_gap", result, {64'd1, 64'd60});

      do_start(60, 1, 0);
      stop = 1'b1;
      run_idle(200);
      chk("start_with_stop", result, {64'd1, 64'd60});

      rnd_ready = 1'b1;
      do_start(1514, 1, 0);
      repeat (10) tick();
      #2 rst = 1'b1;
      #1;
      chk("midrst_valid", axis_m_valid, 1'b0);
      chk("midrst_ready", ready, 1'b1);
      chk("midrst_result", result, '0);
      m_active = 1'b0;
      m_frames = '0;
      m_bytes = '0;
      m_beat = 0;
      m_ts_known = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      tick();
      do_start(60, 1, 0);
      run_idle(200);
      chk("after_rst", result, {64'd1, 64'd60});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/frame_generator.md
Name: frame_generator

Overview:
Transmit-side counterpart of the frame checker in the speed tester. On start it emits a configurable stream of test Ethernet frames on an AXIS master interface, each carrying a sequence number and a transmit timestamp. It runs until a frame-count limit or a stop command, and reports frames/bytes sent. It sits between the control/CSR logic and the MAC TX path (FCS appended downstream).

Parameters:
DATA_WIDTH, 512, AXIS data width in bits; fixed 64 bytes per beat.
ID_WIDTH, 3, AXIS TID width (egress port select).

Ports:
clk  in  1  single clock
rst  in  1  asynchronous, active-high reset
ready  out  1  high when idle and able to accept start
start  in  1  single-cycle pulse; samples all cfg_* ports
stop  in  1  single-cycle pulse; finish current frame, then idle
cfg_frame_len  in  11  frame length in bytes excluding FCS
cfg_frame_count  in  32  frames to send; 0 = unlimited
cfg_gap  in  16  idle cycles inserted after each frame
cfg_dst_mac  in  48  destination MAC
cfg_src_mac  in  48  source MAC
cfg_id  in  ID_WIDTH  TID for all frames
result  out  128  {frames_sent[63:0], bytes_sent[63:0]}
axis_m_data  out  DATA_WIDTH  frame data, byte 0 in bits [7:0]
axis_m_keep  out  DATA_WIDTH/8  byte enables
axis_m_last  out  1  last beat of frame
axis_m_user  out  DATA_WIDTH/8  always 0
axis_m_id  out  ID_WIDTH  latched cfg_id
axis_m_valid  out  1  beat valid
axis_m_ready  in  1  downstream ready

Behaviour:
- Reset (async): state IDLE, ready=1, valid=0, last=0, data/keep/user/id=0, result=0, timestamp counter=0, sequence=0.
- Free-running 64-bit cycle counter ts, +1 every cycle from reset, wraps.
- Length clamp at start: L = max(60, min(1514, cfg_frame_len)). Beats N = ceil(L/64), 1..24.
- Frame layout (bytes, big-endian fields): 0-5 dst MAC, 6-11 src MAC, 12-13 ethertype 0x88B5, 14-21 sequence number, 22-29 timestamp, 30..L-1 byte value = (byte index mod 256).
- Last beat keep = low (L mod 64) bits set, or all 64 if L mod 64 = 0; other beats all-ones. Bytes beyond keep driven 0.
- States: IDLE -> SEND on start (ready drops the next cycle; cfg latched; result, sequence cleared). SEND: valid=1; beat index advances only on valid&&ready; data/keep/last stable while stalled. Timestamp latched when the first beat of a frame is first presented, held for the whole frame.
- On last-beat handshake: frames_sent+=1, bytes_sent+=L, sequence+=1; then: if stop_pending or (count!=0 and frames_sent==count) -> IDLE; else if cfg_gap!=0 -> GAP; else next frame begins the following cycle (back-to-back, no bubble).
- GAP: valid=0 for exactly cfg_gap cycles, then SEND. Stop in GAP -> IDLE next cycle.
- stop in SEND sets stop_pending; the frame in progress always completes (no truncated frames). stop in IDLE ignored. start outside IDLE ignored. start and stop in the same IDLE cycle: start taken, stop ignored.
- result holds final values in IDLE until next start.
- Counters 64-bit, wrap silently. Reset mid-frame drops valid immediately; no completion required.

Decomposition:
- Package frame_gen_pkg: ETHERTYPE_TEST=16'h88B5, MIN_LEN=60, MAX_LEN=1514, BEAT_BYTES=64, state encoding (IDLE, SEND, GAP).
- Sub-module frame_beat_builder: combinational; inputs beat index, L, MACs, sequence, timestamp; outputs data, keep, last. Top holds FSM, counters, handshake.

Test Plan:
- start, len=60, count=1, gap=0, ready=1 -> one beat, keep=64'h0FFF_FFFF_FFFF_FFFF, last=1, bytes 12-13 = 88 B5, seq=0; result={1,60}; ready returns 1.
- len=130, count=3, gap=0 -> 9 beats back-to-back, last on beats 3/6/9, last keep=64'h3, seq 0,1,2; result={3,390}.
- len=1514, count=2, random axis_m_ready stalls -> 24 beats per frame, data/keep/last unchanged during stalls, timestamp equal across a frame's beats; result={2,3028}.
- len=64, count=0, gap=5 -> exactly 5 valid-low cycles between frames; stop mid-frame -> frame completes with last, then idle; no further valid.
- len=10 and len=2000 -> clamped to 60 and 1514 bytes; start pulsed while running -> ignored, cfg unchanged.
- Assert rst mid-frame -> valid=0, result=0, ready=1 immediately; subsequent start sends seq 0.
